// File: rtl/mem_arbiter_if.sv
// Word-granular memory request/response port shared by a cache and the memory side.
// master drives the request (addr/wdata/ren/wen) and receives ready/valid/rdata.
interface mem_arbiter_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ren;
    logic        wen;
    logic        ready;
    logic        valid;
    logic [31:0] rdata;

    modport master (output addr, wdata, ren, wen, input  ready, valid, rdata);
    modport slave  (input  addr, wdata, ren, wen, output ready, valid, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between icache and dcache: one-cycle grant, quantum-bounded ownership.
// Ready follows i_mem_ready combinationally; read responses bypass straight to the owner.
module mem_arbiter #(
    parameter int MAX_OUT = 4,
    parameter int QUANTUM = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    mem_arbiter_if.slave  i_imem,
    mem_arbiter_if.slave  i_dmem,
    mem_arbiter_if.master o_mem,
    output logic          o_err
);
    localparam int NW = $clog2(MAX_OUT + 1);
    localparam int QW = $clog2(QUANTUM + 1);
    localparam logic [NW-1:0] N_MAX = NW'(MAX_OUT);
    localparam logic [QW-1:0] Q_MAX = QW'(QUANTUM);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_last_d, w_last_d_nxt;
    logic [QW-1:0] r_q, w_q_nxt;
    logic [NW-1:0] r_n, w_n_nxt;
    logic          r_err;

    logic          w_own_i, w_own_d, w_own;
    logic [31:0]   w_addr, w_wdata;
    logic          w_ren, w_wen, w_req;
    logic          w_gate, w_acc, w_rsp;
    logic          w_ireq, w_dreq;

    assign w_own_i = (r_state == OWN_I);
    assign w_own_d = (r_state == OWN_D);
    assign w_own   = w_own_i | w_own_d;
    assign w_ireq  = i_imem.ren | i_imem.wen;
    assign w_dreq  = i_dmem.ren | i_dmem.wen;

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_ren   = 1'b0;
        w_wen   = 1'b0;
        if (w_own_i) begin
            w_addr  = i_imem.addr;
            w_wdata = i_imem.wdata;
            w_ren   = i_imem.ren;
            w_wen   = i_imem.wen;
        end else if (w_own_d) begin
            w_addr  = i_dmem.addr;
            w_wdata = i_dmem.wdata;
            w_ren   = i_dmem.ren;
            w_wen   = i_dmem.wen;
        end
    end

    // A read is held back once MAX_OUT are in flight; writes are never limited by n.
    assign w_req  = w_ren | w_wen;
    assign w_gate = (r_q < Q_MAX) && !(w_ren && (r_n == N_MAX));
    assign w_acc  = w_own && o_mem.ready && w_gate && w_req;
    assign w_rsp  = o_mem.valid && (r_n != '0);

    assign o_mem.addr   = w_addr;
    assign o_mem.wdata  = w_wdata;
    assign o_mem.ren    = w_ren && w_gate;
    assign o_mem.wen    = w_wen && w_gate;
    assign i_imem.ready = w_own_i && w_acc;
    assign i_dmem.ready = w_own_d && w_acc;
    assign i_imem.valid = w_own_i && w_rsp;
    assign i_dmem.valid = w_own_d && w_rsp;
    assign i_imem.rdata = o_mem.rdata;
    assign i_dmem.rdata = o_mem.rdata;
    assign o_err        = r_err;

    always_comb begin
        w_state_nxt  = r_state;
        w_last_d_nxt = r_last_d;
        w_q_nxt      = r_q;
        w_n_nxt      = r_n;
        case (r_state)
            IDLE: begin
                if (w_dreq && (!w_ireq || !r_last_d)) begin
                    w_state_nxt  = OWN_D;
                    w_last_d_nxt = 1'b1;
                    w_q_nxt      = '0;
                    w_n_nxt      = '0;
                end else if (w_ireq) begin
                    w_state_nxt  = OWN_I;
                    w_last_d_nxt = 1'b0;
                    w_q_nxt      = '0;
                    w_n_nxt      = '0;
                end
            end
            default: begin
                if (w_acc) w_q_nxt = r_q + 1'b1;
                case ({w_acc && w_ren, w_rsp})
                    2'b10:   w_n_nxt = r_n + 1'b1;
                    2'b01:   w_n_nxt = r_n - 1'b1;
                    default: w_n_nxt = r_n;
                endcase
                // Ownership only moves with nothing in flight, so responses cannot be misrouted.
                if ((r_n == '0) && (!w_req || (r_q == Q_MAX))) w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_last_d <= 1'b0;
            r_q      <= '0;
            r_n      <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_last_d <= w_last_d_nxt;
            r_q      <= w_q_nxt;
            r_n      <= w_n_nxt;
            if (o_mem.valid && (r_n == '0)) r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: two holding requesters, an in-order memory model
// with random latency, and a transaction-level reference model checked every cycle.
module tb_mem_arbiter;
    localparam int MAX_OUT = 4;
    localparam int QUANTUM = 8;

    logic clk = 1'b0;
    logic rst;
    logic err;
    always #5 clk = ~clk;

    mem_arbiter_if imem ();
    mem_arbiter_if dmem ();
    mem_arbiter_if mem ();

    mem_arbiter #(.MAX_OUT(MAX_OUT), .QUANTUM(QUANTUM)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .i_imem(imem),
        .i_dmem(dmem),
        .o_mem (mem),
        .o_err (err)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        int          who;   // 1 = I, 2 = D, 0 = abandoned by reset
    } rsp_t;

    rsp_t rq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // reference model: current owner (0 none, 1 I, 2 D), last grantee, accepted-this-grant count
    int   m_own = 0;
    int   m_last = 1;
    int   m_q = 0;
    bit   m_err = 0;

    // stimulus knobs
    bit   want_rst = 1, quiet = 1, stray = 0, rdy_always = 0;
    int   p_req = 7, dly_max = 4;

    bit          r_act[2], r_isrd[2];
    logic [31:0] r_addr[2], r_wd[2];
    bit          cur_ren[2], cur_wen[2];
    logic [31:0] cur_addr[2], cur_wd[2];
    bit          cur_mrdy, cur_mvld;
    logic [31:0] cur_mrd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive();
        cyc++;
        rst = want_rst;
        for (int k = 0; k < 2; k++) begin
            if (quiet) r_act[k] = 1'b0;
            else if (!r_act[k] && ($urandom_range(0, 9) < p_req)) begin
                r_act[k]  = 1'b1;
                r_isrd[k] = 1'($urandom_range(0, 1));
                r_addr[k] = $urandom;
                r_wd[k]   = $urandom;
            end
            cur_ren[k]  = r_act[k] && r_isrd[k];
            cur_wen[k]  = r_act[k] && !r_isrd[k];
            cur_addr[k] = r_act[k] ? r_addr[k] : $urandom;
            cur_wd[k]   = r_act[k] ? r_wd[k] : $urandom;
        end
        imem.ren = cur_ren[0]; imem.wen = cur_wen[0]; imem.addr = cur_addr[0]; imem.wdata = cur_wd[0];
        dmem.ren = cur_ren[1]; dmem.wen = cur_wen[1]; dmem.addr = cur_addr[1]; dmem.wdata = cur_wd[1];
        cur_mrdy = rdy_always || ($urandom_range(0, 3) != 0);
        cur_mvld = stray || (rq.size() > 0 && rq[0].due <= cyc);
        cur_mrd  = (!stray && rq.size() > 0) ? rq[0].data : $urandom;
        mem.ready = cur_mrdy;
        mem.valid = cur_mvld;
        mem.rdata = cur_mrd;
    endtask

    task automatic step();
        int          n, k, who;
        bit          oren, owen, can, acc, rel;
        logic [31:0] eaddr, ewd;
        bit          eren, ewen;
        rsp_t        e;
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        n = 0;
        foreach (rq[i]) if (rq[i].who != 0) n++;
        k = 0; oren = 0; owen = 0; can = 0; acc = 0;
        eaddr = '0; ewd = '0; eren = 0; ewen = 0;
        if (m_own != 0) begin
            k     = m_own - 1;
            oren  = cur_ren[k];
            owen  = cur_wen[k];
            eaddr = cur_addr[k];
            ewd   = cur_wd[k];
            can   = (m_q < QUANTUM) && !(oren && n == MAX_OUT);
            eren  = oren && can;
            ewen  = owen && can;
            acc   = cur_mrdy && can && (oren || owen);
        end
        // a response belongs to whoever issued the oldest live read
        who = 0;
        if (cur_mvld && !stray && rq.size() > 0) who = rq[0].who;

        chk("mem_addr",  mem.addr,   eaddr);
        chk("mem_wdata", mem.wdata,  ewd);
        chk("mem_ren",   32'(mem.ren),  32'(eren));
        chk("mem_wen",   32'(mem.wen),  32'(ewen));
        chk("i_ready",   32'(imem.ready), 32'(m_own == 1 && acc));
        chk("d_ready",   32'(dmem.ready), 32'(m_own == 2 && acc));
        chk("i_valid",   32'(imem.valid), 32'(who == 1));
        chk("d_valid",   32'(dmem.valid), 32'(who == 2));
        chk("i_rdata",   imem.rdata, cur_mrd);
        chk("d_rdata",   dmem.rdata, cur_mrd);
        chk("err",       32'(err),   32'(m_err));

        if (cur_mvld) begin
            if (who == 0) m_err = 1;
            if (!stray && rq.size() > 0) void'(rq.pop_front());
        end
        rel = (m_own != 0) && (n == 0) && (!(oren || owen) || m_q == QUANTUM);
        if (acc) begin
            r_act[k] = 1'b0;
            m_q++;
            if (oren) begin
                e.due = cyc + int'($urandom_range(1, dly_max));
                if (rq.size() > 0 && e.due <= rq[$].due) e.due = rq[$].due + 1;
                e.data = $urandom;
                e.who  = m_own;
                rq.push_back(e);
            end
        end
        if (m_own == 0) begin
            bit ri, rd;
            ri = cur_ren[0] || cur_wen[0];
            rd = cur_ren[1] || cur_wen[1];
            if (ri && rd)  m_own = (m_last == 1) ? 2 : 1;
            else if (ri)   m_own = 1;
            else if (rd)   m_own = 2;
            if (m_own != 0) begin
                m_last = m_own;
                m_q    = 0;
            end
        end else if (rel) begin
            m_own = 0;
        end
        if (rst) begin
            m_own = 0; m_last = 1; m_q = 0; m_err = 0;
            foreach (rq[i]) rq[i].who = 0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && rq.size() > 0; i++) step();
        chk("drain", 32'(rq.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        imem.ren = 0; imem.wen = 0; imem.addr = '0; imem.wdata = '0;
        dmem.ren = 0; dmem.wen = 0; dmem.addr = '0; dmem.wdata = '0;
        mem.ready = 0; mem.valid = 0; mem.rdata = '0;
        for (int k = 0; k < 2; k++) begin
            r_act[k] = 0; r_isrd[k] = 0; r_addr[k] = '0; r_wd[k] = '0;
        end

        repeat (2) step();
        want_rst = 0; quiet = 0;

        p_req = 9; dly_max = 4;
        repeat (1500) step();
        p_req = 6; dly_max = 12; rdy_always = 1;
        repeat (1000) step();

        // reset with reads in flight: their late responses must flag o_err
        for (int i = 0; i < 200 && rq.size() == 0; i++) step();
        want_rst = 1; step(); want_rst = 0; quiet = 1;
        drain();
        stray = 1; step(); stray = 0;
        repeat (5) step();
        want_rst = 1; step(); want_rst = 0;
        repeat (2) step();

        quiet = 0; p_req = 7; dly_max = 6; rdy_always = 0;
        repeat (800) step();
        quiet = 1;
        drain();
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
